lsu_mem_unit: RTL

- Load/store unit that consumes the decoder's memory controls (mem_type one-hot, dram_en, dram_wen) plus the ALU address and rs2 data.
- Performs one byte/half/word access over a valid/ready memory bus with variable latency.
- Returns sign- or zero-extended load data for the register write-back mux.
- Sits between the execute stage and data memory; the core stalls while the unit is busy.

---
 rtl/lsu_mem_unit_pkg.sv | 44 ++++
 rtl/lsu_mem_unit_align.sv | 57 +++++
 rtl/lsu_mem_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_mem_unit_pkg.sv
// Shared definitions for the load/store unit: mem_type bit positions,
// one-hot codes, FSM state encoding and byte-enable constants.
package npc_lsu_pkg;

  // Bit positions inside the one-hot mem_type vector {lhu,lbu,lw,lh,lb,sw,sh,sb}
  localparam int MT_SB  = 0;
  localparam int MT_SH  = 1;
  localparam int MT_SW  = 2;
  localparam int MT_LB  = 3;
  localparam int MT_LH  = 4;
  localparam int MT_LW  = 5;
  localparam int MT_LBU = 6;
  localparam int MT_LHU = 7;

  // Full one-hot codes, so case statements look at every bit of mem_type
  localparam logic [7:0] OH_SB  = 8'h01;
  localparam logic [7:0] OH_SH  = 8'h02;
  localparam logic [7:0] OH_SW  = 8'h04;
  localparam logic [7:0] OH_LB  = 8'h08;
  localparam logic [7:0] OH_LH  = 8'h10;
  localparam logic [7:0] OH_LW  = 8'h20;
  localparam logic [7:0] OH_LBU = 8'h40;
  localparam logic [7:0] OH_LHU = 8'h80;

  localparam logic [7:0] STORE_BITS = OH_SB | OH_SH | OH_SW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/lsu_mem_unit_align.sv
// Combinational lane logic: store data replication / byte-enable generation
// and load lane extraction with sign or zero extension.
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [7:0]  st_type,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  input  logic [7:0]  ld_type,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata_word,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Store side: replicate the operand across lanes, enable only the addressed bytes
  always_comb begin
    st_wdata = '0;
    st_wmask = MASK_NONE;
    unique case (st_type)
      OH_SB: begin
        st_wdata = {4{wdata[7:0]}};
        st_wmask = MASK_BYTE0 << st_off;
      end
      OH_SH: begin
        st_wdata = {2{wdata[15:0]}};
        st_wmask = st_off[1] ? MASK_HALF_HI : MASK_HALF_LO;
      end
      OH_SW: begin
        st_wdata = wdata;
        st_wmask = MASK_WORD;
      end
      default: begin
        st_wdata = '0;
        st_wmask = MASK_NONE;
      end
    endcase
  end

  // Load side: shift the addressed byte/half down to bit 0, then extend
  always_comb begin
    lane    = rdata_word >> {ld_off, 3'b000};
    ld_data = '0;
    unique case (ld_type)
      OH_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      OH_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      OH_LW:   ld_data = rdata_word;
      OH_LBU:  ld_data = {24'd0, lane[7:0]};
      OH_LHU:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: one byte/half/word access per request over a valid/ready
// bus with variable latency, with alignment checks and an optional timeout.
//
// state | meaning
// IDLE  | ready for a request; checks legality at accept
// REQ   | bus_req_valid high, waiting for bus_req_ready
// RESP  | bus_resp_ready high, waiting for read data / write ack
// DONE  | one-cycle resp_valid pulse with rdata/err
module lsu_mem_unit
  import npc_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [7:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wmask,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  output logic        bus_resp_ready
);

  lsu_state_e       state;
  logic [7:0]       mt_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             bad_req;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wmask;
  logic [31:0]      ld_data;

  lsu_align u_align (
    .st_type    (mem_type),
    .st_off     (addr[1:0]),
    .wdata      (wdata),
    .st_wdata   (st_wdata),
    .st_wmask   (st_wmask),
    .ld_type    (mt_q),
    .ld_off     (off_q),
    .rdata_word (bus_resp_rdata),
    .ld_data    (ld_data)
  );

  // Legality of the incoming request and the timeout terminal count
  always_comb begin
    bad_req = !is_onehot8(mem_type)
           || (req_wen != (|(mem_type & STORE_BITS)))
           || ((mem_type[MT_LW] | mem_type[MT_SW]) && (addr[1:0] != 2'b00))
           || ((mem_type[MT_LH] | mem_type[MT_LHU] | mem_type[MT_SH]) && addr[0]);
    cnt_inc     = cnt + 1'b1;
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));
  end

  // Sequencing FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      bus_req_valid  <= 1'b0;
      bus_resp_ready <= 1'b0;
      bus_req_wen    <= 1'b0;
      bus_req_addr   <= '0;
      bus_req_wdata  <= '0;
      bus_req_wmask  <= '0;
      mt_q           <= '0;
      off_q          <= '0;
      cnt            <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mt_q          <= mem_type;
            off_q         <= addr[1:0];
            bus_req_wen   <= req_wen;
            bus_req_addr  <= {addr[31:2], 2'b00};
            bus_req_wdata <= st_wdata;
            bus_req_wmask <= st_wmask;
            cnt           <= '0;
            req_ready     <= 1'b0;
            rdata         <= '0;
            if (bad_req) begin
              err        <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_DONE;
            end else begin
              err           <= 1'b0;
              bus_req_valid <= 1'b1;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid  <= 1'b0;
            bus_resp_ready <= 1'b1;
            cnt            <= '0;
            state          <= ST_RESP;
          end else if (timeout_hit) begin
            bus_req_valid <= 1'b0;
            err           <= 1'b1;
            resp_valid    <= 1'b1;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESP: begin
          if (bus_resp_valid) begin
            bus_resp_ready <= 1'b0;
            rdata          <= bus_req_wen ? 32'd0 : ld_data;
            resp_valid     <= 1'b1;
            state          <= ST_DONE;
          end else if (timeout_hit) begin
            bus_resp_ready <= 1'b0;
            err            <= 1'b1;
            resp_valid     <= 1'b1;
            state          <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
